// File: rtl/id_wb_arbiter.sv
// Round-robin arbiter that shares the single register-file write port between
// NUM_REQ writeback sources and drives a registered write command one cycle after each grant.
module id_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          hold_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*6-1:0]          req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          we_o,
  output logic [5:0]                    w_addr_o,
  output logic [DATA_WIDTH-1:0]         w_data_o,
  output logic [2:0]                    grant_idx_o,
  output logic [15:0]                   drop_cnt_o
);

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);
  localparam logic [2:0]         LAST_IDX  = 3'(NUM_REQ - 1);

  logic [5:0]            addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [2:0]            cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]    cand_onehot [NUM_REQ];

  logic [2:0]            ptr_reg;
  logic [2:0]            ptr_next;
  logic                  we_reg;
  logic [5:0]            w_addr_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [2:0]            grant_idx_reg;
  logic [15:0]           drop_cnt_reg;

  logic                  arb_en;
  logic                  grant_found;
  logic [2:0]            grant_idx_next;
  logic [NUM_REQ-1:0]    grant_vec;
  logic [5:0]            sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_is_x0;

  // Unpack requester fields and precompute the round-robin search order,
  // offset gi from the pointer wrapped modulo NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [3:0] rot_sum;

      assign addr_arr[gi]    = req_addr_i[6*gi +: 6];
      assign data_arr[gi]    = req_data_i[DATA_WIDTH*gi +: DATA_WIDTH];
      assign rot_sum         = {1'b0, ptr_reg} + 4'(gi);
      assign cand_idx[gi]    = (rot_sum >= 4'(NUM_REQ)) ? 3'(rot_sum - 4'(NUM_REQ))
                                                        : rot_sum[2:0];
      assign cand_onehot[gi] = ONE_HOT_0 << cand_idx[gi];
    end
  endgenerate

  // Ready is held low in reset so nothing is consumed before the pointer is valid.
  assign arb_en = rst_ni & ~hold_i;

  always_comb begin
    grant_found    = 1'b0;
    grant_idx_next = '0;
    grant_vec      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (arb_en && !grant_found && |(req_valid_i & cand_onehot[off])) begin
        grant_found    = 1'b1;
        grant_idx_next = cand_idx[off];
        grant_vec      = cand_onehot[off];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_vec[j]) begin
        sel_addr = addr_arr[j];
        sel_data = data_arr[j];
      end
    end
  end

  assign sel_is_x0 = (sel_addr == 6'd0);
  assign ptr_next  = (grant_idx_next == LAST_IDX) ? 3'd0 : grant_idx_next + 3'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg       <= '0;
      we_reg        <= 1'b0;
      w_addr_reg    <= '0;
      w_data_reg    <= '0;
      grant_idx_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      // x0 writes are consumed like any other but never reach the register file.
      we_reg <= grant_found & ~sel_is_x0;
      if (grant_found) begin
        ptr_reg       <= ptr_next;
        w_addr_reg    <= sel_addr;
        w_data_reg    <= sel_data;
        grant_idx_reg <= grant_idx_next;
        if (sel_is_x0 && drop_cnt_reg != 16'hFFFF) begin
          drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign req_ready_o = grant_vec;
  assign we_o        = we_reg;
  assign w_addr_o    = w_addr_reg;
  assign w_data_o    = w_data_reg;
  assign grant_idx_o = grant_idx_reg;
  assign drop_cnt_o  = drop_cnt_reg;

endmodule

// File: tb/tb_id_wb_arbiter.sv
// Directed bench for id_wb_arbiter: reset, round-robin rotation, single requester,
// x0 suppression, hold and mid-stream reset, all against hand-computed values.
module tb_id_wb_arbiter;

  localparam int DW = 64;
  localparam int NR = 3;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           hold_i;
  logic [NR-1:0]  req_valid_i;
  logic [NR*6-1:0]  req_addr_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]  req_ready_o;
  logic           we_o;
  logic [5:0]     w_addr_o;
  logic [DW-1:0]  w_data_o;
  logic [2:0]     grant_idx_o;
  logic [15:0]    drop_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [5:0]    a0, a1, a2;
  logic [DW-1:0] d0, d1, d2;

  id_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .hold_i      (hold_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .we_o        (we_o),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o),
    .grant_idx_o (grant_idx_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_reqs();
    req_addr_i = {a2, a1, a0};
    req_data_i = {d2, d1, d0};
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk_i);
    #2;
    cyc++;
    $display("[TB] cyc %0d we=%0b addr=%0d data=%0h gidx=%0d drop=%0d",
             cyc, we_o, w_addr_o, w_data_o, grant_idx_o, drop_cnt_o);
  endtask

  initial begin
    a0 = 6'd1; a1 = 6'd2; a2 = 6'd3;
    d0 = 64'h1111; d1 = 64'h2222; d2 = 64'h3333;
    pack_reqs();
    rst_ni      = 1'b0;
    hold_i      = 1'b0;
    req_valid_i = 3'b111;

    // Reset held with every requester asking.
    tick();
    tick();
    #1;
    check_eq("rst_ready", 64'(req_ready_o), 64'h0);
    check_eq("rst_we",    64'(we_o),        64'h0);
    check_eq("rst_addr",  64'(w_addr_o),    64'h0);
    check_eq("rst_gidx",  64'(grant_idx_o), 64'h0);
    check_eq("rst_drop",  64'(drop_cnt_o),  64'h0);
    rst_ni = 1'b1;
    #1;
    check_eq("rel_ready", 64'(req_ready_o), 64'b001);
    tick();
    #1;
    check_eq("first_we",   64'(we_o),        64'h1);
    check_eq("first_addr", 64'(w_addr_o),    64'(a0));
    check_eq("first_data", w_data_o,         d0);
    check_eq("first_gidx", 64'(grant_idx_o), 64'h0);

    // Continuous requests rotate 1,2,0,1,2,0 starting from pointer 1.
    for (int k = 0; k < 6; k++) begin
      check_eq("rr_ready", 64'(req_ready_o), 64'(3'b001 << ((1 + k) % 3)));
      tick();
      #1;
      check_eq("rr_we",   64'(we_o),        64'h1);
      check_eq("rr_gidx", 64'(grant_idx_o), 64'((1 + k) % 3));
    end

    // Lone requester 1; pointer was left at 1.
    a1 = 6'd5; d1 = 64'hDEAD_BEEF;
    pack_reqs();
    req_valid_i = 3'b010;
    #1;
    check_eq("solo_ready", 64'(req_ready_o), 64'b010);
    tick();
    #1;
    check_eq("solo_we",   64'(we_o),     64'h1);
    check_eq("solo_addr", 64'(w_addr_o), 64'd5);
    check_eq("solo_data", w_data_o,      64'hDEAD_BEEF);
    req_valid_i = 3'b101;
    #1;
    check_eq("ptr2_ready", 64'(req_ready_o), 64'b100);
    tick();
    #1;
    check_eq("ptr2_gidx", 64'(grant_idx_o), 64'd2);
    check_eq("ptr2_addr", 64'(w_addr_o),    64'(a2));

    // x0 write is accepted but suppressed; f0 is a normal write.
    a0 = 6'd0;
    pack_reqs();
    req_valid_i = 3'b001;
    #1;
    check_eq("x0_ready", 64'(req_ready_o), 64'b001);
    tick();
    #1;
    check_eq("x0_we",   64'(we_o),       64'h0);
    check_eq("x0_drop", 64'(drop_cnt_o), 64'd1);
    a0 = 6'd32;
    pack_reqs();
    #1;
    check_eq("f0_ready", 64'(req_ready_o), 64'b001);
    tick();
    #1;
    check_eq("f0_we",   64'(we_o),       64'h1);
    check_eq("f0_addr", 64'(w_addr_o),   64'd32);
    check_eq("f0_drop", 64'(drop_cnt_o), 64'd1);

    // Hold with everyone valid; pointer is 1 going in.
    a0 = 6'd1;
    pack_reqs();
    req_valid_i = 3'b111;
    hold_i = 1'b1;
    #1;
    check_eq("hold_ready0", 64'(req_ready_o), 64'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check_eq("hold_we",    64'(we_o),        64'h0);
      check_eq("hold_ready", 64'(req_ready_o), 64'h0);
    end
    hold_i = 1'b0;
    #1;
    check_eq("unhold_ready", 64'(req_ready_o), 64'b010);
    tick();
    #1;
    check_eq("unhold_we",   64'(we_o),        64'h1);
    check_eq("unhold_gidx", 64'(grant_idx_o), 64'd1);

    // Reset in the middle of a write cycle.
    tick();
    #1;
    check_eq("pre_rst_we",   64'(we_o),        64'h1);
    check_eq("pre_rst_gidx", 64'(grant_idx_o), 64'd2);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_we",    64'(we_o),        64'h0);
    check_eq("mid_rst_drop",  64'(drop_cnt_o),  64'h0);
    check_eq("mid_rst_ready", 64'(req_ready_o), 64'h0);
    check_eq("mid_rst_gidx",  64'(grant_idx_o), 64'h0);
    tick();
    rst_ni = 1'b1;
    #1;
    check_eq("restart_ready", 64'(req_ready_o), 64'b001);
    tick();
    #1;
    check_eq("restart_we",   64'(we_o),        64'h1);
    check_eq("restart_gidx", 64'(grant_idx_o), 64'h0);
    check_eq("restart_addr", 64'(w_addr_o),    64'(a0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
